// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds, a read-valid qualifier and overflow / underflow
// error reporting. Storage is a register array; the read port is registered
// (data appears one cycle after an accepted read).
//
// Parameters:
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries (power of two, >= 4)
//   AF_THRESH  almost_full  when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   wr_en/wr_data write request and data
//   rd_en         read request
//   rd_data       registered read data (holds when no read is accepted)
//   rd_valid      rd_data was updated by a read accepted on the previous edge
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      write rejected
//   underflow     read attempted while empty
//
// Build option: define SYNC_FIFO_STICKY_ERR_EN to make overflow/underflow
// sticky (set on error, cleared only by reset). Without it they are
// single-cycle pulses. Data path, pointers and count are the same either way.
// ----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Elaboration-time parameter legality.
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if ((AE_THRESH < 0) || !(AE_THRESH < AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_param: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;
  logic              unf_evt;

  always_comb begin
    // A read frees a slot in the same cycle, so a write into a full FIFO
    // is still accepted when paired with a read. A write into an empty FIFO
    // never satisfies a simultaneous read (no bypass).
    rd_acc  = rd_en && !empty_q;
    wr_acc  = wr_en && (!full_q || rd_acc);
    ovf_evt = wr_en && !wr_acc;
    unf_evt = rd_en && empty_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_acc ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags come from the next count so they line up with count_q.
    full_d         = (count_d == DEPTH_CNT);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);

    rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;

`ifdef SYNC_FIFO_STICKY_ERR_EN
    overflow_d  = overflow_q  | ovf_evt;
    underflow_d = underflow_q | unf_evt;
`else
    overflow_d  = ovf_evt;
    underflow_d = unf_evt;
`endif
  end

  // Storage has no reset; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// A queue-based reference model predicts every output after each clock; each
// output is compared with an immediate assertion. Honors
// SYNC_FIFO_STICKY_ERR_EN for the error-flag expectations.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] model_q[$];
  logic [7:0] exp_rd_data = 8'h00;
  bit         exp_rd_valid = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         exp_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step_name);
    int n;
    n = model_q.size();
    chk({step_name, ":count"},        32'(count),        32'(n));
    chk({step_name, ":full"},         32'(full),         32'(n == DEPTH));
    chk({step_name, ":empty"},        32'(empty),        32'(n == 0));
    chk({step_name, ":almost_full"},  32'(almost_full),  32'(n >= AF));
    chk({step_name, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({step_name, ":rd_valid"},     32'(rd_valid),     32'(exp_rd_valid));
    chk({step_name, ":rd_data"},      32'(rd_data),      32'(exp_rd_data));
    chk({step_name, ":overflow"},     32'(overflow),     32'(exp_ovf));
    chk({step_name, ":underflow"},    32'(underflow),    32'(exp_unf));
  endtask

  // One clock: drive inputs, update the model, clock, then check outputs.
  task automatic step(input string step_name, input bit rst, input bit we,
                      input logic [7:0] wd, input bit re);
    bit was_full, was_empty, r_ok, w_ok;
    reset   = rst;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    if (rst) begin
      model_q.delete();
      exp_rd_data  = 8'h00;
      exp_rd_valid = 1'b0;
      exp_ovf      = 1'b0;
      exp_unf      = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      r_ok = re && !was_empty;
      w_ok = we && (!was_full || r_ok);
`ifdef SYNC_FIFO_STICKY_ERR_EN
      exp_ovf = exp_ovf || (we && !w_ok);
      exp_unf = exp_unf || (re && was_empty);
`else
      exp_ovf = we && !w_ok;
      exp_unf = re && was_empty;
`endif
      exp_rd_valid = r_ok;
      if (r_ok) exp_rd_data = model_q.pop_front();
      if (w_ok) model_q.push_back(wd);
    end
    @(posedge clk);
    #1;
    check_all(step_name);
    $display("step %-10s rst=%0b we=%0b wd=%02h re=%0b -> count=%0d rd_valid=%0b rd_data=%02h ovf=%0b unf=%0b",
             step_name, rst, we, wd, re, count, rd_valid, rd_data, overflow, underflow);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

    // Reset state.
    step("reset", 1, 0, 8'h00, 0);
    step("reset2", 1, 0, 8'h00, 0);

    // Basic order: write 0x01..0x10, then read all 16 back.
    for (int i = 1; i <= 16; i++) step("wr_basic", 0, 1, 8'(i), 0);
    for (int i = 0; i < 16; i++) step("rd_basic", 0, 0, 8'h00, 1);

    // Overflow: fill, then write 0xAA without a read.
    for (int i = 0; i < 16; i++) step("fill_ovf", 0, 1, 8'(8'h80 + i), 0);
    step("overflow", 0, 1, 8'hAA, 0);
    step("ovf_idle", 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      step("rd_ovf", 0, 0, 8'h00, 1);
      chk("no_AA", 32'(rd_data == 8'hAA), 32'(0));
    end

    // Underflow on empty, then idle cycles (sticky build keeps it high).
    step("underflow", 0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step("unf_idle", 0, 0, 8'h00, 0);

    // Full + simultaneous read/write of 0x55.
    for (int i = 0; i < 16; i++) step("fill_sim", 0, 1, 8'(8'h40 + i), 0);
    step("full_rw", 0, 1, 8'h55, 1);
    for (int i = 0; i < 16; i++) step("rd_sim", 0, 0, 8'h00, 1);
    chk("last_is_55", 32'(rd_data), 32'h55);

    // Empty + simultaneous read/write of 0x33: no bypass, underflow event.
    step("empty_rw", 0, 1, 8'h33, 1);
    step("rd_33", 0, 0, 8'h00, 1);
    chk("got_33", 32'(rd_data), 32'h33);

    // Wrap: 40 writes with interleaved random reads, then drain.
    for (int i = 0; i < 40; i++) step("wrap", 0, 1, 8'($urandom), bit'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) step("drain", 0, 0, 8'h00, 1);

    // Fully random traffic.
    for (int i = 0; i < 300; i++)
      step("random", 0, bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));

    // Reset with 9 entries held.
    for (int i = 0; i < 20; i++) step("drain2", 0, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) step("fill9", 0, 1, 8'($urandom), 0);
    chk("count9", 32'(count), 32'd9);
    step("midreset", 1, 1, 8'hFF, 1);
    step("post_rst", 0, 0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x16 buffer.
- Adds configurable width and depth, full/empty protection, occupancy count, almost-full/almost-empty thresholds, a read-valid qualifier and overflow/underflow error reporting.
- Sits between producer and consumer stages in the same clock domain.
- Storage is a register array; the read port is registered.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH
(ADDR_W = clog2(DEPTH) is derived internally; it is not a user parameter.)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  rd_data was updated by an accepted read this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  write rejected (see Behaviour)
underflow  out  1  read rejected (see Behaviour)

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
- Reset takes priority over every other input. Reset mid-operation discards all contents. Storage array is not cleared.
- Acceptance rules:
  - wr_acc = wr_en && (!full || rd_acc).
  - rd_acc = rd_en && !empty.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments with modulo-DEPTH wrap (DEPTH-1 -> 0).
- Accepted read: rd_data <= mem[rd_ptr]; rd_valid=1 in the following cycle; rd_ptr increments with modulo-DEPTH wrap.
  - Latency: data is visible 1 cycle after the accepted rd_en edge.
- No accepted read: rd_data holds its last value; rd_valid=0.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- All flags are registered, derived from the next count, and consistent with count in the same cycle.
- Simultaneous read and write:
  - When full: both are accepted and count stays DEPTH. The read returns the oldest entry; the new word takes the freed slot.
  - When empty: the write is accepted and the read is rejected; count becomes 1. The new word is never bypassed to rd_data.
- overflow: 1-cycle pulse the cycle after wr_en && !wr_acc. State unchanged.
- underflow: 1-cycle pulse the cycle after rd_en && empty. rd_data unchanged.
- Pointers never advance on rejected requests. Data ordering is strictly first-in first-out across pointer wrap.
- Threshold legality (AE_THRESH < AF_THRESH <= DEPTH) is checked at elaboration. An illegal setting is a fatal error.

Optional Feature:
- Macro: SYNC_FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Each sets on its error condition and stays 1 until reset; there is no other clear path.
- Undefined: overflow and underflow are the 1-cycle pulses described in Behaviour.
- Data path, pointers and count are identical in both builds.

Test Plan:
All scenarios use DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
- Basic order: reset; write 0x01..0x10 (16 words); read 16 -> rd_data 0x01..0x10 in order, each with rd_valid 1 cycle after rd_en; count 16->0; empty=1 at end.
- Flags: write 2 -> almost_empty=1; write 3rd -> almost_empty=0; at count 14 -> almost_full=1; at 16 -> full=1.
- Overflow: full, wr_en with 0xAA, rd_en=0 -> overflow pulse; count stays 16; subsequent 16 reads never return 0xAA.
- Underflow: empty, rd_en=1 -> underflow pulse, rd_valid=0, rd_data unchanged.
  - With SYNC_FIFO_STICKY_ERR_EN: underflow stays 1 for 10 idle cycles.
- Simultaneous operations:
  - Full + rd_en + wr_en(0x55): count stays 16; 0x55 returned as the 16th subsequent read.
  - Empty + rd_en + wr_en(0x33): count=1, underflow pulse; next read returns 0x33.
- Wrap and reset: run 40 writes/reads interleaved (pointers wrap twice) with data-order check; assert reset with count=9 -> next cycle count=0, empty=1, rd_data=0, flags at reset values.
